// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: digit count, dark constants and the hex -> active-low a..g decode.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  // Bit 0 of the result is segment a, bit 6 is segment g; 0 lights the segment.
  function automatic logic [0:6] hex2seg(input logic [3:0] h);
    logic [0:6] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low a..g segment decoder.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [0:6] seg
);

  assign seg = hex2seg(hex);

endmodule

// File: rtl/display_mux_7seg.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-slot anti-ghost blanking.
// Optional macro BLANK_LEADING_ZEROS_EN darkens leading-zero digits (digit0 always lit).
module display_mux_7seg
  import seg7_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int SCAN_FREQ    = 240,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic [15:0]           num,
  input  logic [NUM_DIGITS-1:0] en,
  output logic [0:6]            SSeg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int TICK = CLK_FREQ / (NUM_DIGITS * SCAN_FREQ);
  localparam int CW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [31:0] TICK_LAST = 32'(TICK - 1);
  localparam logic [31:0] BLANK_U   = 32'(BLANK_CYCLES);

  generate
    if (TICK < 1) begin : g_cfg_err
      $error("display_mux_7seg: CLK_FREQ/(4*SCAN_FREQ) must be at least 1");
    end
  endgenerate

  logic [15:0]           val_reg;
  logic [CW-1:0]         cnt_reg;
  logic [1:0]            idx_reg;
  logic [0:6]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;
  logic [NUM_DIGITS-1:0] lz_dark;
  logic [3:0]            nibble;
  logic [0:6]            dec_seg;
  logic                  wrap;
  logic                  show;

  assign wrap   = (32'(cnt_reg) == TICK_LAST);
  assign show   = (32'(cnt_reg) >= BLANK_U);
  assign nibble = val_reg[4*idx_reg +: 4];

  hex_to_7seg u_dec (
    .hex (nibble),
    .seg (dec_seg)
  );

  // A digit is a leading zero when it and every digit above it are zero.
  assign lz_dark[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
`ifdef BLANK_LEADING_ZEROS_EN
      assign lz_dark[gi] = (val_reg[15:4*gi] == '0);
`else
      assign lz_dark[gi] = 1'b0;
`endif
    end
  endgenerate

  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = AN_OFF;
    if (show) begin
      seg_next = dec_seg;
      if (en[idx_reg] && !lz_dark[idx_reg])
        an_next = ~(4'b0001 << idx_reg);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_reg <= '0;
      cnt_reg <= '0;
      idx_reg <= '0;
      SSeg    <= SEG_BLANK;
      an      <= AN_OFF;
    end else begin
      if (ld)
        val_reg <= num;
      if (wrap) begin
        cnt_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      SSeg <= seg_next;
      an   <= an_next;
    end
  end

endmodule
